mcsr_unit: RTL
==============

// Module: mcsr_unit
// PURPOSE
//  Parametrised machine-mode CSR unit: next generation of the core's CSR block. Holds real state
//  (mstatus, mie, mip, mtvec, mepc, mcause, mtval, mscratch, 64-bit mcycle/minstret),
//  performs trap entry/mret, and prioritises NUM_IRQ platform interrupts. Sits beside the
//  execute stage; the core sees a redirect one cycle after any trap/mret.
// PARAMETERS
//  XLEN         32            register width (32 only supported; checked at elaboration)
//  NUM_IRQ      4             platform interrupt lines, mapped to mip/mie bits 16..16+NUM_IRQ-1 (1..16)
//  CAUSE_W      6             width of trap_cause
//  MTVEC_RESET  32'h0000_0000 mtvec reset value
//  VECTORED_EN  1             1: mtvec mode 1 honoured; 0: mode forced to 0
// PORTS
//  CLK          in   1        clock
//  RST          in   1        one clock; reset is synchronous and active-high
//  csr_req      in   1        CSR access valid this cycle
//  csr_op       in   2        00 read, 01 write, 10 set, 11 clear
//  csr_addr     in   12       CSR address
//  csr_wdata    in   XLEN     write/set/clear operand
//  csr_rdata    out  XLEN     combinational read data (pre-update value)
//  csr_illegal  out  1        combinational: access is illegal, no state change
//  trap_valid   in   1        take synchronous exception or interrupt this cycle
//  trap_is_irq  in   1        1 = interrupt (mcause MSB set)
//  trap_cause   in   CAUSE_W  cause code
//  trap_pc      in   XLEN     pc to save in mepc
//  trap_tval    in   XLEN     value for mtval
//  mret_valid   in   1        execute mret
//  instret_inc  in   1        one instruction retired
//  ext_irq      in   NUM_IRQ  platform interrupt levels
//  timer_irq    in   1        MTIP level;  sw_irq in 1 MSIP level
//  redirect_valid out 1       1-cycle pulse, cycle after trap/mret
//  redirect_pc  out  XLEN     target for redirect_valid
//  irq_pending  out  1        mstatus.MIE & |(mip & mie)
//  irq_cause    out  CAUSE_W  highest-priority pending enabled interrupt
// BEHAVIOUR
//  Reset: mstatus=32'h0000_1800 (MPP=3), mtvec=MTVEC_RESET, all other CSRs/counters 0,
//   redirect_valid=0, redirect_pc=0, irq_pending=0, irq_cause=0. RST overrides all inputs.
//  Addresses: 300 mstatus(MIE b3, MPIE b7, MPP b12:11 RO=3), 304 mie, 344 mip(RO), 305 mtvec,
//   340 mscratch, 341 mepc(b0 RZ), 342 mcause, 343 mtval, B00/B80 mcycle lo/hi,
//   B02/B82 minstret lo/hi, F14 mhartid(=0). Others -> illegal.
//  Illegal also: any non-read op to addr[11:10]==2'b11 or to mip. Set/clear with wdata=0 is not a write.
//  CSR write/set/clear commits at the clock edge; csr_rdata shows the old value.
//  mip: bit11=|ext_irq, bit7=timer_irq, bit3=sw_irq, bit16+i=ext_irq[i]; sampled each cycle (1-cycle lag).
//  Priority for irq_cause: 11 > 3 > 7 > 16+i (lowest i first). irq_pending registered-input combinational.
//  mtvec WARL: mode 2/3 or VECTORED_EN=0 -> mode 0.
//  Trap (trap_valid): mepc<=trap_pc&~1, mcause<={trap_is_irq,0..,trap_cause}, mtval<=trap_tval,
//   MPIE<=MIE, MIE<=0; next cycle redirect_pc=base+(mode1&&trap_is_irq ? 4*cause : 0).
//  mret: MIE<=MPIE, MPIE<=1, redirect_pc=mepc.
//  Simultaneous: trap > mret > CSR write; lower-priority event is dropped entirely (no partial update).
//  Counters: mcycle +1 every cycle, minstret +instret_inc; 64-bit wrap to 0. A CSR write to either
//   half replaces that half and suppresses the increment for that counter that cycle.
// STRUCTURE
//  csr_pkg: CSR address constants, csr_op encoding, interrupt cause codes, mstatus bit positions.
//  Sub-module csr_counter64 (inc, wr_lo, wr_hi, wdata, value[63:0]) instantiated twice.
// TESTING
//  Reset then read 300/305/B00 -> 32'h1800, MTVEC_RESET, small nonzero cycle count; no redirect.
//  Write 305=32'h8000_0001, set mie bit11, MIE=1, raise ext_irq[0] -> irq_pending after 1 cycle,
//   irq_cause=11; trap(irq,11,pc=0x100) -> redirect_pc=0x8000_002C, mepc=0x100, MIE=0, MPIE=1.
//  mret after above -> redirect_pc=0x100, MIE=1, MPIE=1.
//  trap_valid & mret_valid & write 340 same cycle -> trap taken, mscratch unchanged, MIE=0.
//  Write B00=32'hFFFF_FFFF, B80=0 -> next cycle mcycle={1,0} (carry into high).
//  Write to F14, write to 344, read 0x7C0 -> csr_illegal=1, no CSR changes.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR unit: CSR addresses, access op
// encoding, interrupt cause codes and mstatus bit positions.
package csr_pkg;

   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MIE       = 12'h304;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MTVAL     = 12'h343;
   localparam logic [11:0] ADDR_MIP       = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
   localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

   typedef enum logic [1:0] {
      CSR_READ  = 2'b00,
      CSR_WRITE = 2'b01,
      CSR_SET   = 2'b10,
      CSR_CLEAR = 2'b11
   } csr_op_e;

   // Interrupt cause codes double as mip/mie bit positions.
   localparam int IRQ_MSI       = 3;
   localparam int IRQ_MTI       = 7;
   localparam int IRQ_MEI       = 11;
   localparam int IRQ_PLAT_BASE = 16;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam logic [1:0] MPP_MACHINE = 2'b11;

   localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
   localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// A write to either half takes the place of the increment for that cycle.
module csr_counter64 (
   input  logic        CLK,
   input  logic        RST,
   input  logic        inc,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wdata,
   output logic [63:0] value
);

   // Half-word write wins over increment; wraps to zero after all-ones.
   always_ff @(posedge CLK) begin
      if (RST) begin
         value <= '0;
      end else if (wr_lo) begin
         value[31:0] <= wdata;
      end else if (wr_hi) begin
         value[63:32] <= wdata;
      end else if (inc) begin
         value <= value + 64'd1;
      end
   end

endmodule

// File: rtl/mcsr_unit.sv
// Machine-mode CSR unit: CSR state, trap entry / mret, interrupt
// prioritisation and the one-cycle-late redirect to the core.
module mcsr_unit
   import csr_pkg::*;
#(
   parameter int          XLEN        = 32,
   parameter int          NUM_IRQ     = 4,
   parameter int          CAUSE_W     = 6,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter bit          VECTORED_EN = 1'b1
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               csr_req,
   input  logic [1:0]         csr_op,
   input  logic [11:0]        csr_addr,
   input  logic [XLEN-1:0]    csr_wdata,
   output logic [XLEN-1:0]    csr_rdata,
   output logic               csr_illegal,
   input  logic               trap_valid,
   input  logic               trap_is_irq,
   input  logic [CAUSE_W-1:0] trap_cause,
   input  logic [XLEN-1:0]    trap_pc,
   input  logic [XLEN-1:0]    trap_tval,
   input  logic               mret_valid,
   input  logic               instret_inc,
   input  logic [NUM_IRQ-1:0] ext_irq,
   input  logic               timer_irq,
   input  logic               sw_irq,
   output logic               redirect_valid,
   output logic [XLEN-1:0]    redirect_pc,
   output logic               irq_pending,
   output logic [CAUSE_W-1:0] irq_cause
);

   if (XLEN != 32) begin : g_bad_xlen
      $error("mcsr_unit: only XLEN=32 is supported");
   end
   if (NUM_IRQ < 1 || NUM_IRQ > 16) begin : g_bad_num_irq
      $error("mcsr_unit: NUM_IRQ must be 1..16");
   end

   // Only implemented interrupt bits of mie are writable.
   localparam logic [XLEN-1:0] IRQ_MASK =
      XLEN'(32'h0000_0888 | (((32'd1 << NUM_IRQ) - 32'd1) << IRQ_PLAT_BASE));

   csr_op_e           op;
   logic              mstatus_mie, mstatus_mpie;
   logic [XLEN-1:0]   mie_q, mip_q, mip_d, mscratch_q, mepc_q, mcause_q, mtval_q;
   logic [XLEN-3:0]   mtvec_base;
   logic [1:0]        mtvec_mode;
   logic [63:0]       mcycle, minstret;
   logic [XLEN-1:0]   rd_val, wval, mstatus_rd, pend, trap_target;
   logic              addr_ok, is_ro, access_bad, is_write, csr_we;

   assign op         = csr_op_e'(csr_op);
   assign mstatus_rd = {19'b0, MPP_MACHINE, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};

   // Read mux (pre-update values) and address decode.
   always_comb begin
      rd_val  = '0;
      addr_ok = 1'b1;
      case (csr_addr)
         ADDR_MSTATUS:   rd_val = mstatus_rd;
         ADDR_MIE:       rd_val = mie_q;
         ADDR_MIP:       rd_val = mip_q;
         ADDR_MTVEC:     rd_val = {mtvec_base, mtvec_mode};
         ADDR_MSCRATCH:  rd_val = mscratch_q;
         ADDR_MEPC:      rd_val = mepc_q;
         ADDR_MCAUSE:    rd_val = mcause_q;
         ADDR_MTVAL:     rd_val = mtval_q;
         ADDR_MCYCLE:    rd_val = mcycle[31:0];
         ADDR_MCYCLEH:   rd_val = mcycle[63:32];
         ADDR_MINSTRET:  rd_val = minstret[31:0];
         ADDR_MINSTRETH: rd_val = minstret[63:32];
         ADDR_MHARTID:   rd_val = '0;
         default:        addr_ok = 1'b0;
      endcase
   end

   assign is_ro       = (csr_addr[11:10] == 2'b11) || (csr_addr == ADDR_MIP);
   assign access_bad  = !addr_ok || ((op != CSR_READ) && is_ro);
   assign csr_illegal = csr_req && access_bad;
   assign csr_rdata   = rd_val;

   // New value for write/set/clear, built from the pre-update read value.
   always_comb begin
      wval = rd_val;
      case (op)
         CSR_WRITE: wval = csr_wdata;
         CSR_SET:   wval = rd_val | csr_wdata;
         CSR_CLEAR: wval = rd_val & ~csr_wdata;
         default:   wval = rd_val;
      endcase
   end

   // Set/clear with a zero operand is a pure read; traps and mret
   // take precedence and drop the CSR write entirely.
   assign is_write = (op == CSR_WRITE) ||
                     (((op == CSR_SET) || (op == CSR_CLEAR)) && (csr_wdata != '0));
   assign csr_we   = csr_req && !access_bad && is_write && !trap_valid && !mret_valid;

   // Interrupt lines as they appear in mip.
   always_comb begin
      mip_d                             = '0;
      mip_d[IRQ_MSI]                    = sw_irq;
      mip_d[IRQ_MTI]                    = timer_irq;
      mip_d[IRQ_MEI]                    = |ext_irq;
      mip_d[IRQ_PLAT_BASE +: NUM_IRQ]   = ext_irq;
   end

   assign pend        = mip_q & mie_q;
   assign irq_pending = mstatus_mie && (pend != '0);

   // Priority 11 > 3 > 7 > 16+i (lowest i first): later assignments win.
   always_comb begin
      irq_cause = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pend[IRQ_PLAT_BASE + i]) irq_cause = CAUSE_W'(IRQ_PLAT_BASE + i);
      end
      if (pend[IRQ_MTI]) irq_cause = CAUSE_W'(IRQ_MTI);
      if (pend[IRQ_MSI]) irq_cause = CAUSE_W'(IRQ_MSI);
      if (pend[IRQ_MEI]) irq_cause = CAUSE_W'(IRQ_MEI);
   end

   // Vectored mode offsets interrupts only; exceptions go to the base.
   assign trap_target = {mtvec_base, 2'b00} +
      (((mtvec_mode == MTVEC_MODE_VECTORED) && trap_is_irq) ? (XLEN'(trap_cause) << 2) : '0);

   // CSR state, trap entry, mret and redirect generation.
   always_ff @(posedge CLK) begin
      if (RST) begin
         mstatus_mie    <= 1'b0;
         mstatus_mpie   <= 1'b0;
         mie_q          <= '0;
         mip_q          <= '0;
         mtvec_base     <= MTVEC_RESET[31:2];
         mtvec_mode     <= MTVEC_RESET[1:0];
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         mip_q          <= mip_d;
         redirect_valid <= trap_valid || mret_valid;
         if (trap_valid) begin
            mepc_q       <= {trap_pc[XLEN-1:1], 1'b0};
            mcause_q     <= {trap_is_irq, {(XLEN-1-CAUSE_W){1'b0}}, trap_cause};
            mtval_q      <= trap_tval;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
            redirect_pc  <= trap_target;
         end else if (mret_valid) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
            redirect_pc  <= mepc_q;
         end else if (csr_we) begin
            case (csr_addr)
               ADDR_MSTATUS: begin
                  mstatus_mie  <= wval[MSTATUS_MIE];
                  mstatus_mpie <= wval[MSTATUS_MPIE];
               end
               ADDR_MIE:      mie_q <= wval & IRQ_MASK;
               ADDR_MTVEC: begin
                  mtvec_base <= wval[XLEN-1:2];
                  mtvec_mode <= (VECTORED_EN && (wval[1:0] == MTVEC_MODE_VECTORED)) ?
                                MTVEC_MODE_VECTORED : MTVEC_MODE_DIRECT;
               end
               ADDR_MSCRATCH: mscratch_q <= wval;
               ADDR_MEPC:     mepc_q     <= {wval[XLEN-1:1], 1'b0};
               ADDR_MCAUSE:   mcause_q   <= wval;
               ADDR_MTVAL:    mtval_q    <= wval;
               default:       ;
            endcase
         end
      end
   end

   csr_counter64 u_mcycle (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (1'b1),
      .wr_lo (csr_we && (csr_addr == ADDR_MCYCLE)),
      .wr_hi (csr_we && (csr_addr == ADDR_MCYCLEH)),
      .wdata (wval),
      .value (mcycle)
   );

   csr_counter64 u_minstret (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (instret_inc),
      .wr_lo (csr_we && (csr_addr == ADDR_MINSTRET)),
      .wr_hi (csr_we && (csr_addr == ADDR_MINSTRETH)),
      .wdata (wval),
      .value (minstret)
   );

endmodule
